control_code_pipe: RTL and testbench
====================================

CONTROL_CODE_PIPE -- requirements
Module: control_code_pipe

Interface
REQ-001 Parameter OPW, default 8: opcode width in bits.
REQ-002 Parameter CW, default 10: decoded control-word width in bits.
REQ-003 Parameter SW, default 3: side-band width, i.e. control bits pre-decoded by the previous generator.
REQ-004 Parameter STAGES, default 2, legal range 1..4: number of registered control stages.
REQ-005 Port clk, input, 1 bit: system-wide clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1 bit: reset; asynchronous and active-high.
REQ-007 Port opcode, input, OPW bits: opcode from the opcode buffer.
REQ-008 Port valid_in, input, 1 bit: opcode is valid this cycle.
REQ-009 Port bubble_in, input, 1 bit: hold this stage; replace the incoming opcode with NOP (all zeros).
REQ-010 Port freeze, input, 1 bit: every stage holds its current contents.
REQ-011 Port flush, input, 1 bit: every stage is cleared to NOP.
REQ-012 Port side_in, input, SW bits: pre-decoded bits from the previous generator stage.
REQ-013 Port ctrl_out, output, CW bits: control word of the last stage.
REQ-014 Port side_out, output, SW bits: side-band bits of the last stage.
REQ-015 Port valid_out, output, 1 bit: last stage holds a real (non-bubble) instruction.
REQ-016 Port hold_next, output, 1 bit: bit CW-1 (HOLD) of stage 0's word; upstream inserts a bubble next cycle.

Function
REQ-017 Decode is combinational: dec = ccg_decode(eff_op), where eff_op = 0 when bubble_in=1 or valid_in=0, else opcode.
REQ-018 ccg_decode(0) SHALL return all zeros; any opcode absent from the table also SHALL decode to all zeros.
REQ-019 Stage 0 SHALL register {dec, side_in, valid_in & ~bubble_in} on each non-frozen edge.
REQ-020 Stage k (k ≥ 1) SHALL register stage k-1 on each non-frozen edge.
REQ-021 Latency: opcode to ctrl_out is exactly STAGES cycles when no freeze occurs.
REQ-022 Priority order: rst > flush > freeze > bubble_in.
REQ-023 Flush SHALL clear every stage's word, side-band and valid bits to 0 at the next edge, including stage 0 capturing that cycle's opcode.
REQ-024 Freeze SHALL hold all stages unchanged; the opcode presented during freeze is discarded. Upstream must re-present it.
REQ-025 flush and freeze asserted together: flush wins.
REQ-026 hold_next SHALL be forced to 0 while stage 0's valid bit is 0.
REQ-027 Outputs are registered; no combinational path from any input to any output except through the freeze/flush-gated registers.

Reset
REQ-028 While rst=1, all stage words, side-band bits and valid bits are 0; ctrl_out=0, side_out=0, valid_out=0, hold_next=0.
REQ-029 Reset asserted mid-pipeline discards all in-flight instructions; the first valid opcode after release appears at ctrl_out after STAGES edges.

Configuration
REQ-030 Macro CCP_PERF_CNT_EN: when defined, add output bubble_cnt (16 bits), reset to 0.
REQ-031 bubble_cnt increments by 1 on each edge where stage 0 captures a bubble (bubble_in=1 or valid_in=0) and freeze=0 and flush=0; it saturates at 16'hFFFF.
REQ-032 When CCP_PERF_CNT_EN is undefined, the port and counter are absent and behaviour is otherwise identical.

Structure
REQ-033 Package ccp_pkg SHALL hold the opcode localparams, the control-bit index localparams (HOLD = CW-1) and the function ccg_decode.
REQ-034 Sub-module ccp_stage SHALL implement one register stage (word + side + valid, with freeze/flush); it is instantiated STAGES times via generate.
REQ-035 Decode is not a separate module; it uses the package function.

Verification
REQ-036 STAGES=2: opcode 8'h01 with valid_in=1 at cycle 0 -> ctrl_out = ccg_decode(8'h01) and valid_out=1 at cycle 2, then 0 at cycle 3 if followed by NOPs.
REQ-037 Opcode 8'h04 (HOLD bit set) with bubble_in=1 -> hold_next=0 and stage contents 0; the same opcode with bubble_in=0 -> hold_next=1 one cycle later.
REQ-038 Three back-to-back opcodes, freeze high for 2 cycles after the first -> outputs hold; the second and third opcodes are lost unless re-presented; ordering is preserved.
REQ-039 Pipeline full of valid ops, flush=1 and freeze=1 in the same cycle -> the next edge gives valid_out=0, ctrl_out=0, hold_next=0.
REQ-040 rst pulse asynchronous to clk mid-stream -> outputs are 0 immediately, without waiting for an edge.
REQ-041 With CCP_PERF_CNT_EN: preload bubble_cnt near 16'hFFFE and apply 5 bubbles -> bubble_cnt saturates at 16'hFFFF; a bubble during freeze is not counted.

Source files
------------

// File: rtl/ccp_pkg.sv
// Purpose : shared opcode values, control-bit indices and the opcode decoder
//           used by the control-code pipeline.
// Ports   : none (package).
// The decoder is written for the default CCP_OPW/CCP_CW widths. HOLD is
// always the top control bit.
package ccp_pkg;

    localparam int CCP_OPW = 8;
    localparam int CCP_CW  = 10;

    // Opcodes
    localparam logic [CCP_OPW-1:0] OP_NOP   = 8'h00;
    localparam logic [CCP_OPW-1:0] OP_ADD   = 8'h01;
    localparam logic [CCP_OPW-1:0] OP_SUB   = 8'h02;
    localparam logic [CCP_OPW-1:0] OP_LOAD  = 8'h03;
    localparam logic [CCP_OPW-1:0] OP_MUL   = 8'h04;
    localparam logic [CCP_OPW-1:0] OP_STORE = 8'h05;
    localparam logic [CCP_OPW-1:0] OP_BR    = 8'h06;

    // Control-word bit indices
    localparam int CB_ALU_EN  = 0;
    localparam int CB_ALU_SUB = 1;
    localparam int CB_MEM_RD  = 2;
    localparam int CB_MEM_WR  = 3;
    localparam int CB_REG_WE  = 4;
    localparam int CB_BR_EN   = 5;
    localparam int CB_IMM_SEL = 6;
    localparam int CB_WB_MEM  = 7;
    localparam int CB_FLAG_WE = 8;
    localparam int CB_HOLD    = CCP_CW - 1;

    // Opcodes that take extra cycles downstream (MUL, BR) raise HOLD so the
    // upstream generator inserts a bubble behind them.
    function automatic logic [CCP_CW-1:0] ccg_decode(input logic [CCP_OPW-1:0] op);
        logic [CCP_CW-1:0] c;
        c = '0;
        case (op)
            OP_ADD: begin
                c[CB_ALU_EN]  = 1'b1;
                c[CB_REG_WE]  = 1'b1;
                c[CB_FLAG_WE] = 1'b1;
            end
            OP_SUB: begin
                c[CB_ALU_EN]  = 1'b1;
                c[CB_ALU_SUB] = 1'b1;
                c[CB_REG_WE]  = 1'b1;
                c[CB_FLAG_WE] = 1'b1;
            end
            OP_LOAD: begin
                c[CB_MEM_RD]  = 1'b1;
                c[CB_REG_WE]  = 1'b1;
                c[CB_IMM_SEL] = 1'b1;
                c[CB_WB_MEM]  = 1'b1;
            end
            OP_MUL: begin
                c[CB_ALU_EN]  = 1'b1;
                c[CB_REG_WE]  = 1'b1;
                c[CB_HOLD]    = 1'b1;
            end
            OP_STORE: begin
                c[CB_MEM_WR]  = 1'b1;
                c[CB_IMM_SEL] = 1'b1;
            end
            OP_BR: begin
                c[CB_BR_EN]   = 1'b1;
                c[CB_IMM_SEL] = 1'b1;
                c[CB_HOLD]    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_code_pipe_if.sv
// Purpose : groups the opcode-in / control-word-out signals of control_code_pipe.
// Ports   : master drives opcode, valid_in, bubble_in, freeze, flush, side_in;
//           slave (the pipe) drives ctrl_out, side_out, valid_out, hold_next
//           and, with CCP_PERF_CNT_EN defined, bubble_cnt.
interface control_code_pipe_if #(
    parameter int OPW = 8,
    parameter int CW  = 10,
    parameter int SW  = 3
);
    logic [OPW-1:0] opcode;
    logic           valid_in;
    logic           bubble_in;
    logic           freeze;
    logic           flush;
    logic [SW-1:0]  side_in;
    logic [CW-1:0]  ctrl_out;
    logic [SW-1:0]  side_out;
    logic           valid_out;
    logic           hold_next;
`ifdef CCP_PERF_CNT_EN
    logic [15:0]    bubble_cnt;
`endif

    modport master (
        output opcode, valid_in, bubble_in, freeze, flush, side_in,
`ifdef CCP_PERF_CNT_EN
        input  bubble_cnt,
`endif
        input  ctrl_out, side_out, valid_out, hold_next
    );

    modport slave (
        input  opcode, valid_in, bubble_in, freeze, flush, side_in,
`ifdef CCP_PERF_CNT_EN
        output bubble_cnt,
`endif
        output ctrl_out, side_out, valid_out, hold_next
    );
endinterface

// File: rtl/ccp_stage.sv
// Purpose : one registered control stage (word + side-band + valid).
// Latency : 1 cycle; flush clears to NOP, freeze holds (flush wins).
// Ports   : clk/rst, freeze/flush, *_in from previous stage, *_q registered.
module ccp_stage #(
    parameter int CW = 10,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          flush,
    input  logic [CW-1:0] word_in,
    input  logic [SW-1:0] side_in,
    input  logic          valid_in,
    output logic [CW-1:0] word_q,
    output logic [SW-1:0] side_q,
    output logic          valid_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            side_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            word_q  <= '0;
            side_q  <= '0;
            valid_q <= 1'b0;
        end else if (!freeze) begin
            word_q  <= word_in;
            side_q  <= side_in;
            valid_q <= valid_in;
        end
    end

endmodule

// File: rtl/control_code_pipe.sv
// Purpose : decodes opcodes into control words and carries them down STAGES registers.
// Latency : STAGES cycles opcode -> ctrl_out; freeze stalls all stages, flush clears them.
// Backpr. : no ready; upstream re-presents opcodes dropped during freeze and
//           inserts a bubble when hold_next is high.
// Ports   : clk, rst (async, active high), bus (control_code_pipe_if.slave).
// Option  : CCP_PERF_CNT_EN adds a saturating 16-bit bubble counter (bus.bubble_cnt).
module control_code_pipe
    import ccp_pkg::*;
#(
    parameter int OPW    = 8,
    parameter int CW     = 10,
    parameter int SW     = 3,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    control_code_pipe_if.slave bus
);

    // Index 0 is the stage-0 input; index k+1 is the output of stage k.
    logic [CW-1:0] word [STAGES+1];
    logic [SW-1:0] side [STAGES+1];
    logic          vld  [STAGES+1];

    logic [OPW-1:0] eff_op;

    // Bubbles and idle cycles enter the pipe as NOP.
    assign eff_op  = (bus.valid_in && !bus.bubble_in) ? bus.opcode : '0;
    assign word[0] = CW'(ccg_decode(CCP_OPW'(eff_op)));
    assign side[0] = bus.side_in;
    assign vld[0]  = bus.valid_in & ~bus.bubble_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        ccp_stage #(.CW(CW), .SW(SW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .freeze   (bus.freeze),
            .flush    (bus.flush),
            .word_in  (word[k]),
            .side_in  (side[k]),
            .valid_in (vld[k]),
            .word_q   (word[k+1]),
            .side_q   (side[k+1]),
            .valid_q  (vld[k+1])
        );
    end

    assign bus.ctrl_out  = word[STAGES];
    assign bus.side_out  = side[STAGES];
    assign bus.valid_out = vld[STAGES];
    // HOLD of stage 0, masked so a stale word in an invalid slot never stalls.
    assign bus.hold_next = vld[1] & word[1][CW-1];

`ifdef CCP_PERF_CNT_EN
    logic        cap_bubble;
    logic [15:0] bubble_cnt_q;

    assign cap_bubble = (bus.bubble_in | ~bus.valid_in) & ~bus.freeze & ~bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (cap_bubble && bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_control_code_pipe.sv
// Purpose : self-checking bench for control_code_pipe (STAGES=2): vector table
//           plus hand-written freeze, async-reset and counter sequences.
// Ports   : none; clk 10 time-unit period, inputs driven and outputs sampled on negedge.
module tb_control_code_pipe;

    logic clk;
    logic rst;

    int n_pass  = 0;
    int n_total = 0;

    control_code_pipe_if #(.OPW(8), .CW(10), .SW(3)) bus ();

    control_code_pipe #(.OPW(8), .CW(10), .SW(3), .STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed control words for the decoder table.
    localparam logic [9:0] W_ADD   = 10'h111;
    localparam logic [9:0] W_SUB   = 10'h113;
    localparam logic [9:0] W_LOAD  = 10'h0D4;
    localparam logic [9:0] W_MUL   = 10'h211;
    localparam logic [9:0] W_STORE = 10'h048;
    localparam logic [9:0] W_BR    = 10'h260;

    typedef struct {
        logic [7:0] op;
        logic       v;
        logic       b;
        logic       fz;
        logic       fl;
        logic [2:0] side;
        logic [9:0] e_ctrl;
        logic [2:0] e_side;
        logic       e_vld;
        logic       e_hold;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic chk_out(input string name, input logic [9:0] c, input logic [2:0] s,
                           input logic v, input logic h);
        chk({name, " ctrl"},  32'(bus.ctrl_out),  32'(c));
        chk({name, " side"},  32'(bus.side_out),  32'(s));
        chk({name, " valid"}, 32'(bus.valid_out), 32'(v));
        chk({name, " hold"},  32'(bus.hold_next), 32'(h));
    endtask

    // Called at a negedge: apply inputs, let one posedge pass, return at next negedge.
    task automatic drive(input logic [7:0] op, input logic v, input logic b,
                         input logic fz, input logic fl, input logic [2:0] s);
        bus.opcode    = op;
        bus.valid_in  = v;
        bus.bubble_in = b;
        bus.freeze    = fz;
        bus.flush     = fl;
        bus.side_in   = s;
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Expected outputs after the edge that consumes each vector's inputs.
        //           op     v     b     fz    fl    side  e_ctrl   e_side e_vld e_hold
        tbl[0]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 10'h000, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, W_ADD,   3'd5, 1'b1, 1'b0};
        tbl[2]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h000, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 10'h000, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 10'h000, 3'd0, 1'b0, 1'b1};
        tbl[5]  = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, W_MUL,   3'd2, 1'b1, 1'b0};
        tbl[6]  = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, W_SUB,   3'd1, 1'b1, 1'b0};
        tbl[7]  = '{8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, W_LOAD,  3'd7, 1'b1, 1'b0};
        tbl[8]  = '{8'h06, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 10'h000, 3'd6, 1'b0, 1'b1};
        tbl[9]  = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 10'h000, 3'd6, 1'b0, 1'b1};
        tbl[10] = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, W_BR,    3'd4, 1'b1, 1'b0};
        tbl[11] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, W_STORE, 3'd2, 1'b1, 1'b0};
        tbl[12] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 10'h000, 3'd1, 1'b1, 1'b0};
        tbl[13] = '{8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 10'h000, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h000, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{8'h06, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 10'h000, 3'd0, 1'b0, 1'b0};
        tbl[16] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'h000, 3'd0, 1'b0, 1'b0};

        // Reset state, including valid opcodes presented while reset is held.
        rst = 1'b1;
        bus.opcode = 8'h00; bus.valid_in = 1'b0; bus.bubble_in = 1'b0;
        bus.freeze = 1'b0;  bus.flush = 1'b0;    bus.side_in = 3'd0;
        #1;
        chk_out("reset", 10'h000, 3'd0, 1'b0, 1'b0);
        bus.opcode = 8'h01; bus.valid_in = 1'b1; bus.side_in = 3'd7;
        repeat (2) @(negedge clk);
        chk_out("reset_held", 10'h000, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        bus.opcode = 8'h00; bus.valid_in = 1'b0; bus.side_in = 3'd0;

        // Vector table.
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].op, tbl[i].v, tbl[i].b, tbl[i].fz, tbl[i].fl, tbl[i].side);
            chk_out($sformatf("vec%0d", i), tbl[i].e_ctrl, tbl[i].e_side,
                    tbl[i].e_vld, tbl[i].e_hold);
        end

        // Freeze for two cycles behind ADD; SUB/LOAD are lost and re-presented.
        drive(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        drive(8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
        chk("frz1 valid", 32'(bus.valid_out), 32'(1'b0));
        drive(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
        chk("frz2 valid", 32'(bus.valid_out), 32'(1'b0));
        drive(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        chk_out("frz_a", W_ADD, 3'd1, 1'b1, 1'b0);
        drive(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        chk_out("frz_b", W_SUB, 3'd2, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk_out("frz_c", W_LOAD, 3'd3, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk_out("frz_end", 10'h000, 3'd0, 1'b0, 1'b0);

        // Asynchronous reset between edges with the pipe full.
        drive(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4);
        drive(8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5);
        chk_out("pre_rst", W_ADD, 3'd4, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        bus.opcode = 8'h00; bus.valid_in = 1'b0; bus.side_in = 3'd0;
        #1;
        chk_out("async_rst", 10'h000, 3'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        drive(8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        chk("post_rst lat1 valid", 32'(bus.valid_out), 32'(1'b0));
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk_out("post_rst", W_STORE, 3'd2, 1'b1, 1'b0);

`ifdef CCP_PERF_CNT_EN
        // Bubble counter: count from reset up to FFFD, freeze, then saturate.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("cnt reset", 32'(bus.bubble_cnt), 32'h0);
        bus.valid_in = 1'b0; bus.freeze = 1'b0; bus.flush = 1'b0;
        repeat (65533) @(negedge clk);
        chk("cnt fffd", 32'(bus.bubble_cnt), 32'hFFFD);
        drive(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        chk("cnt frozen", 32'(bus.bubble_cnt), 32'hFFFD);
        for (int i = 0; i < 5; i++) drive(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("cnt sat", 32'(bus.bubble_cnt), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
